// File: rtl/ram_rom_pkg.sv
// ram_rom_pkg: default widths and the fixed ROM program table.
// The table holds ROM[a] = a for 0..6; slot 7 is unused and reads 0.
package ram_rom_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_RAM_ADDR_W = 4;
    localparam int DEF_ROM_ADDR_W = 3;
    localparam int DEF_ROM_DATA_W = 3;
    localparam int ROM_DEPTH      = 1 << DEF_ROM_ADDR_W;

    localparam logic [DEF_ROM_DATA_W-1:0] ROM_TABLE [ROM_DEPTH] = '{
        3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0
    };

    function automatic logic [DEF_ROM_DATA_W-1:0] rom_word(
        input logic [DEF_ROM_ADDR_W-1:0] a
    );
        return ROM_TABLE[a];
    endfunction

endpackage

// File: rtl/ram_rom_storage.sv
// ram_rom_storage: RAM array with a write-through registered read port.
// With RAM_CLEAR_EN defined, reset also clears every word.
module ram_rom_storage
    import ram_rom_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RAM_ADDR_W = DEF_RAM_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ram_enable,
    input  logic                  we,
    input  logic [RAM_ADDR_W-1:0] addr_ram,
    input  logic [DATA_W-1:0]     data_in,
    output logic [DATA_W-1:0]     data_out
);

    localparam int DEPTH = 1 << RAM_ADDR_W;

    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] dout_d;
    logic              wr_en;

    assign wr_en = ram_enable & we;

`ifdef RAM_CLEAR_EN
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[addr_ram] <= data_in;
        end
    end
`else
    // Power-up contents are zero; reset leaves the array untouched.
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

    always_ff @(posedge clock) begin
        if (reset && wr_en) begin
            mem_q[addr_ram] <= data_in;
        end
    end
`endif

    always_comb begin
        dout_d = dout_q;
        if (ram_enable) begin
            dout_d = we ? data_in : mem_q[addr_ram];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign data_out = dout_q;

endmodule

// File: rtl/ram_rom.sv
// ram_rom: independent RAM port and registered constant ROM lookup.
// Optional macro RAM_CLEAR_EN makes reset clear the RAM array too.
module ram_rom
    import ram_rom_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RAM_ADDR_W = DEF_RAM_ADDR_W,
    parameter int ROM_ADDR_W = DEF_ROM_ADDR_W,
    parameter int ROM_DATA_W = DEF_ROM_DATA_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ram_enable,
    input  logic                  we,
    input  logic [RAM_ADDR_W-1:0] addr_ram,
    input  logic [DATA_W-1:0]     data_in,
    output logic [DATA_W-1:0]     data_out,
    input  logic                  rom_enable,
    input  logic [ROM_ADDR_W-1:0] pc_count,
    output logic [ROM_DATA_W-1:0] opcode
);

    logic [ROM_DATA_W-1:0] opcode_q;
    logic [ROM_DATA_W-1:0] opcode_d;

    ram_rom_storage #(
        .DATA_W     (DATA_W),
        .RAM_ADDR_W (RAM_ADDR_W)
    ) u_storage (
        .clock      (clock),
        .reset      (reset),
        .ram_enable (ram_enable),
        .we         (we),
        .addr_ram   (addr_ram),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    always_comb begin
        opcode_d = opcode_q;
        if (rom_enable) begin
            opcode_d = ROM_DATA_W'(rom_word(DEF_ROM_ADDR_W'(pc_count)));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            opcode_q <= '0;
        end else begin
            opcode_q <= opcode_d;
        end
    end

    assign opcode = opcode_q;

endmodule

// File: tb/tb_ram_rom.sv
// tb_ram_rom: directed scenarios plus random traffic against an array model.
// Define RAM_CLEAR_EN for both RTL and bench to check the clearing variant.
module tb_ram_rom;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int RW    = 3;
    localparam int OW    = 3;
    localparam int DEPTH = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          ram_enable = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] addr_ram = '0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          rom_enable = 1'b0;
    logic [RW-1:0] pc_count = '0;
    logic [OW-1:0] opcode;

    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] dout_m;
    logic [OW-1:0] op_m;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    ram_rom dut (
        .clock      (clock),
        .reset      (reset),
        .ram_enable (ram_enable),
        .we         (we),
        .addr_ram   (addr_ram),
        .data_in    (data_in),
        .data_out   (data_out),
        .rom_enable (rom_enable),
        .pc_count   (pc_count),
        .opcode     (opcode)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OW-1:0] rom_ref(input int a);
        return (a < 7) ? OW'(a) : '0;
    endfunction

    task automatic model_reset();
        dout_m = '0;
        op_m   = '0;
`ifdef RAM_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
`endif
    endtask

    task automatic step(input string tag, input logic re, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic oe, input logic [RW-1:0] pc);
        ram_enable = re;
        we         = w;
        addr_ram   = a;
        data_in    = d;
        rom_enable = oe;
        pc_count   = pc;
        @(posedge clock);
        if (reset) begin
            if (re && w) begin
                mem_m[a] = d;
                dout_m   = d;
            end else if (re) begin
                dout_m = mem_m[a];
            end
            if (oe) op_m = rom_ref(int'(pc));
        end
        #1;
        check({tag, ".dout"}, 32'(data_out), 32'(dout_m));
        check({tag, ".op"}, 32'(opcode), 32'(op_m));
    endtask

    // Pulse reset between edges; called 1 time unit after an edge.
    task automatic reset_pulse(input string tag);
        #1 reset = 1'b0;
        #1;
        model_reset();
        check({tag, ".async_dout"}, 32'(data_out), 32'h0);
        check({tag, ".async_op"}, 32'(opcode), 32'h0);
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        dout_m = '0;
        op_m   = '0;

        #2 reset = 1'b0;
        ram_enable = 1'b1;
        we         = 1'b1;
        addr_ram   = 4'd3;
        data_in    = 8'hFF;
        rom_enable = 1'b1;
        pc_count   = 3'd5;
        #2;
        check("rst_dout", 32'(data_out), 32'h0);
        check("rst_op", 32'(opcode), 32'h0);
        @(posedge clock);
        #1;
        check("rst_hold_dout", 32'(data_out), 32'h0);
        check("rst_hold_op", 32'(opcode), 32'h0);
        #2 reset = 1'b1;

        step("rd3_unwritten", 1, 0, 4'd3, 8'h00, 1, 3'd0);
        step("wr5", 1, 1, 4'd5, 8'hA5, 0, 3'd0);
        step("rd5", 1, 0, 4'd5, 8'h00, 0, 3'd0);

        step("wr2", 1, 1, 4'd2, 8'h3C, 0, 3'd0);
        for (int i = 0; i < 3; i++)
            step("idle2", 0, 1, 4'd2, DW'($urandom), 0, 3'd0);
        step("rd2", 1, 0, 4'd2, 8'h00, 0, 3'd0);

        for (int p = 0; p < 8; p++)
            step($sformatf("rom%0d", p), 0, 0, 4'd0, 8'h00, 1, RW'(p));
        step("rom_hold_a", 0, 0, 4'd0, 8'h00, 0, 3'd3);
        step("rom_hold_b", 0, 0, 4'd0, 8'h00, 0, 3'd4);
        step("rom6", 0, 0, 4'd0, 8'h00, 1, 3'd6);
        step("rom_hold6", 0, 0, 4'd0, 8'h00, 0, 3'd2);

        step("wr9", 1, 1, 4'd9, 8'h77, 0, 3'd0);
        reset_pulse("pulse9");
        step("rd9", 1, 0, 4'd9, 8'h00, 0, 3'd0);

        step("wr1_rom4", 1, 1, 4'd1, 8'h11, 1, 3'd4);
        step("rd1", 1, 0, 4'd1, 8'h00, 0, 3'd0);

        for (int n = 0; n < 400; n++) begin
            step("rand", 1'($urandom), 1'($urandom), AW'($urandom),
                 DW'($urandom), 1'($urandom), RW'($urandom));
            if ($urandom_range(0, 29) == 0) reset_pulse("rand_pulse");
        end

        for (int a = 0; a < DEPTH; a++)
            step($sformatf("sweep%0d", a), 1, 0, AW'(a), 8'h00, 1, RW'(a));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
